// File: rtl/miner_job_ctrl.sv
// miner_job_ctrl: job sequencer in front of the SHA-256d miner core.
// Host words land in a shadow bank, job_commit moves them to a one-deep
// pending slot, and the FSM launches pending jobs on the core and
// returns each result over a valid/ready port.
// Optional build macro: MINER_JOB_TIMER_EN adds a per-job cycle counter
// and the res_cycles output.
module miner_job_ctrl #(
  parameter int NONCE_LAT = 132
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         job_commit,
  input  logic         ovf_clr,
  output logic         pending_full,
  output logic         busy,
  output logic         overflow,
  output logic         core_start,
  output logic         core_use_nonce_in,
  output logic         core_oneshot,
  output logic [607:0] core_hdr,
  output logic [31:0]  core_nonce_in,
  input  logic         core_done,
  input  logic         core_found,
  input  logic [31:0]  core_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic [31:0]  res_nonce,
  output logic [7:0]   res_job_id
`ifdef MINER_JOB_TIMER_EN
  ,
  output logic [31:0]  res_cycles
`endif
);

  // Core latency is informational; a non-positive value is simply a bad
  // configuration and creates no hardware either way.
  if (NONCE_LAT <= 0) begin : g_nonce_lat_invalid
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAITLOW,
    S_RUN,
    S_REPORT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_launch;
  logic        w_capture;
  logic        w_accept;
  logic        w_commit_ok;
  logic        w_commit_rej;

  // Words 0..19 (header plus nonce_start); ctrl keeps only its used fields.
  logic [31:0] r_sh [20];
  logic        r_sh_oneshot;
  logic [7:0]  r_sh_id;

  logic [31:0] r_pd [20];
  logic        r_pd_oneshot;
  logic [7:0]  r_pd_id;
  logic        r_pend_full;

  logic [31:0] r_act [20];
  logic        r_act_oneshot;
  logic [7:0]  r_act_id;

  logic        r_ovf;
  logic        r_res_valid;
  logic        r_res_found;
  logic [31:0] r_res_nonce;
  logic [7:0]  r_res_id;
  logic [607:0] w_core_hdr;

  // A commit is judged on the occupancy seen at the start of the cycle,
  // so a launch vacating the slot in the same cycle does not rescue it.
  assign w_commit_ok  = job_commit && !r_pend_full;
  assign w_commit_rej = job_commit &&  r_pend_full;

  // FSM state register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and the single-cycle event strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_full && core_done) begin
          w_launch    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH:  w_state_nxt = S_WAITLOW;
      S_WAITLOW: if (!core_done) w_state_nxt = S_RUN;
      S_RUN: begin
        if (core_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        if (r_res_valid && res_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow bank: word writes from the host; addresses 21..31 are dropped.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < 20; k++) r_sh[k] <= '0;
      r_sh_oneshot <= 1'b0;
      r_sh_id      <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 20; k++) begin
        if (wr_addr == 5'(k)) r_sh[k] <= wr_data;
      end
      if (wr_addr == 5'd20) begin
        r_sh_oneshot <= wr_data[0];
        r_sh_id      <= wr_data[15:8];
      end
    end
  end

  // Pending slot: filled by an accepted commit (pre-write shadow), emptied on launch.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < 20; k++) r_pd[k] <= '0;
      r_pd_oneshot <= 1'b0;
      r_pd_id      <= '0;
      r_pend_full  <= 1'b0;
    end else if (w_launch) begin
      r_pend_full <= 1'b0;
    end else if (w_commit_ok) begin
      for (int k = 0; k < 20; k++) r_pd[k] <= r_sh[k];
      r_pd_oneshot <= r_sh_oneshot;
      r_pd_id      <= r_sh_id;
      r_pend_full  <= 1'b1;
    end
  end

  // Sticky overflow; a rejected commit wins over a simultaneous clear.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)           r_ovf <= 1'b0;
    else if (w_commit_rej) r_ovf <= 1'b1;
    else if (ovf_clr)      r_ovf <= 1'b0;
  end

  // Active job registers: loaded only when leaving IDLE for LAUNCH.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int k = 0; k < 20; k++) r_act[k] <= '0;
      r_act_oneshot <= 1'b0;
      r_act_id      <= '0;
    end else if (w_launch) begin
      for (int k = 0; k < 20; k++) r_act[k] <= r_pd[k];
      r_act_oneshot <= r_pd_oneshot;
      r_act_id      <= r_pd_id;
    end
  end

`ifdef MINER_JOB_TIMER_EN
  logic [31:0] r_cyc;
  logic [31:0] w_cyc_inc;

  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The capture cycle itself is in RUN, so the latched count includes it.
  assign w_cyc_inc = f_sat_inc(r_cyc);

  // Job timer: cleared in LAUNCH, counts every WAITLOW and RUN cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                                       r_cyc <= '0;
    else if (r_state == S_LAUNCH)                      r_cyc <= '0;
    else if (r_state == S_WAITLOW || r_state == S_RUN) r_cyc <= w_cyc_inc;
  end

  logic [31:0] r_res_cycles;

  // Cycle count is latched alongside the other result fields.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)        r_res_cycles <= '0;
    else if (w_capture) r_res_cycles <= w_cyc_inc;
  end

  assign res_cycles = r_res_cycles;
`endif

  // Result registers: captured when the core finishes, held through REPORT.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_res_valid <= 1'b0;
      r_res_found <= 1'b0;
      r_res_nonce <= '0;
      r_res_id    <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_found <= core_found;
      r_res_nonce <= core_nonce;
      r_res_id    <= r_act_id;
    end else if (w_accept) begin
      r_res_valid <= 1'b0;
    end
  end

  // Flatten the active words 0..18 into the core header bus.
  always_comb begin
    w_core_hdr = '0;
    for (int k = 0; k < 19; k++) w_core_hdr[32*k +: 32] = r_act[k];
  end

  assign pending_full      = r_pend_full;
  assign busy              = (r_state != S_IDLE);
  assign overflow          = r_ovf;
  assign core_start        = (r_state == S_LAUNCH);
  assign core_use_nonce_in = 1'b1;
  assign core_oneshot      = r_act_oneshot;
  assign core_hdr          = w_core_hdr;
  assign core_nonce_in     = r_act[19];
  assign res_valid         = r_res_valid;
  assign res_found         = r_res_found;
  assign res_nonce         = r_res_nonce;
  assign res_job_id        = r_res_id;

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Bench for miner_job_ctrl: a behavioural core model plus a job-level
// reference (shadow image, pending queue, overflow flag) feed an expected
// result queue that an independent monitor drains at the result port.
`timescale 1ns/1ps
module tb_miner_job_ctrl;
  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic         job_commit = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         pending_full, busy, overflow, core_start, core_use_nonce_in, core_oneshot;
  logic [607:0] core_hdr;
  logic [31:0]  core_nonce_in;
  logic         core_done, core_found;
  logic [31:0]  core_nonce;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [7:0]   res_job_id;
`ifdef MINER_JOB_TIMER_EN
  logic [31:0]  res_cycles;
`endif

  miner_job_ctrl dut (
    .clk(clk), .arst_n(arst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .job_commit(job_commit), .ovf_clr(ovf_clr), .pending_full(pending_full), .busy(busy),
    .overflow(overflow), .core_start(core_start), .core_use_nonce_in(core_use_nonce_in),
    .core_oneshot(core_oneshot), .core_hdr(core_hdr), .core_nonce_in(core_nonce_in),
    .core_done(core_done), .core_found(core_found), .core_nonce(core_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found),
    .res_nonce(res_nonce), .res_job_id(res_job_id)
`ifdef MINER_JOB_TIMER_EN
    , .res_cycles(res_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  // job image: words 0..19 at [32k+:32], oneshot at bit 640, job_id at [655:648]
  typedef logic [671:0] job_t;
  // result: found[72], nonce[71:40], job_id[39:32], cycles[31:0]
  typedef logic [72:0]  res_t;

  int     n_chk = 0, n_fail = 0;
  job_t   sh = '0;
  job_t   exp_jobs[$];
  res_t   exp_res[$];
  bit     m_ovf = 0;
  int     n_starts = 0, n_results = 0;
  int     lat_force = 0;
  bit     fn_force = 0;
  bit     hold_ready = 0;
  logic [31:0] last_w17 = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [607:0] act, input logic [607:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Core model and job-level reference, evaluated on pre-edge values.
  initial begin
    int   cnt;
    bit   cbusy;
    job_t j;
    logic [7:0] cur_id;
    int   cur_lat;
    bit   n_done, n_found;
    logic [31:0] n_nonce;
    cnt = 0; cbusy = 0; cur_id = '0; cur_lat = 0;
    n_done = 1; n_found = 0; n_nonce = '0;
    core_done = 1'b1; core_found = 1'b0; core_nonce = '0;
    forever begin
      @(posedge clk);
      if (!arst_n) begin
        exp_jobs.delete(); exp_res.delete();
        m_ovf = 0; sh = '0; cbusy = 0; cnt = 0;
        n_done = 1; n_found = 0; n_nonce = '0;
      end else begin
        // a start means the launch emptied the pending slot on the prior edge
        if (core_start) begin
          n_starts++;
          if (exp_jobs.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL core_start_unexpected: got start with no committed job");
          end else begin
            j = exp_jobs.pop_front();
            chk_w("core_hdr", core_hdr, j[607:0]);
            chk("core_nonce_in", core_nonce_in, j[639:608]);
            chk("core_oneshot", core_oneshot, j[640]);
            cur_id = j[655:648];
          end
          last_w17 = core_hdr[17*32 +: 32];
          cur_lat = (lat_force != 0) ? lat_force : $urandom_range(2, 12);
          lat_force = 0;
          cnt = cur_lat; cbusy = 1; n_done = 0;
        end else if (cbusy) begin
          cnt--;
          if (cnt == 0) begin
            if (fn_force) begin
              n_found = 1; n_nonce = 32'h1234_5678; fn_force = 0;
            end else begin
              n_found = 1'($urandom_range(0, 1)); n_nonce = $urandom;
            end
            exp_res.push_back({n_found, n_nonce, cur_id, 32'(cur_lat + 1)});
            cbusy = 0; n_done = 1;
          end
        end
        if (job_commit && exp_jobs.size() > 0) m_ovf = 1;
        else if (ovf_clr)                      m_ovf = 0;
        if (job_commit && exp_jobs.size() == 0) exp_jobs.push_back(sh);
        if (wr_en) begin
          if (wr_addr < 5'd20) sh[int'(wr_addr)*32 +: 32] = wr_data;
          else if (wr_addr == 5'd20) begin
            sh[640] = wr_data[0];
            sh[655:648] = wr_data[15:8];
          end
        end
      end
      #1;
      core_done = n_done; core_found = n_found; core_nonce = n_nonce;
    end
  end

  // Result monitor: pops the expected queue when a result appears and
  // re-checks the held fields every cycle until the handshake.
  initial begin
    res_t cur;
    bit have, pv, pr;
    have = 0; pv = 0; pr = 0; cur = '0;
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        have = 0; pv = 0; pr = 0; res_ready = 1'b0;
      end else begin
        chk("overflow", overflow, m_ovf);
        if (pv && pr) begin
          chk("res_valid_after_hs", res_valid, 1'b0);
          have = 0;
          n_results++;
        end
        if (res_valid) begin
          if (!have) begin
            if (exp_res.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL res_unexpected: got result id %0h with none expected", res_job_id);
              cur = {res_found, res_nonce, res_job_id, 32'h0};
            end else begin
              cur = exp_res.pop_front();
            end
            have = 1;
          end
          chk("res_found", res_found, cur[72]);
          chk("res_nonce", res_nonce, cur[71:40]);
          chk("res_job_id", res_job_id, cur[39:32]);
`ifdef MINER_JOB_TIMER_EN
          chk("res_cycles", res_cycles, cur[31:0]);
`endif
        end
        pv = res_valid;
        pr = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
        res_ready = pr;
      end
    end
  end

  initial begin
    #600000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Stimulus tasks assume they are entered just after a falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_job(input logic [7:0] id, input bit oneshot);
    for (int a = 0; a < 20; a++) wr(5'(a), $urandom);
    wr(5'd20, {16'h0, id, 7'h0, oneshot});
  endtask

  task automatic commit();
    job_commit = 1'b1;
    @(negedge clk);
    job_commit = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int i;
    i = 0;
    while (n_results < target && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("wait_results", n_results, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pending_full"}, pending_full, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_core_start"}, core_start, 1'b0);
    chk({tag, "_use_nonce"}, core_use_nonce_in, 1'b1);
    chk({tag, "_oneshot"}, core_oneshot, 1'b0);
    chk_w({tag, "_core_hdr"}, core_hdr, '0);
    chk({tag, "_nonce_in"}, core_nonce_in, 32'h0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_found"}, res_found, 1'b0);
    chk({tag, "_res_nonce"}, res_nonce, 32'h0);
    chk({tag, "_res_job_id"}, res_job_id, 8'h0);
  endtask

  initial begin
    int s0, tgt, i;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 arst_n = 1'b1;
    @(negedge clk);

    // single job with the fixed core response and timing checks
    load_job(8'h05, 1'b1);
    lat_force = 10; fn_force = 1;
    s0 = n_starts;
    job_commit = 1'b1;
    @(negedge clk);
    job_commit = 1'b0;
    chk("t1_pending_full", pending_full, 1'b1);
    chk("t1_start_early", core_start, 1'b0);
    @(negedge clk);
    chk("t1_start_n2", core_start, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_pending_cleared", pending_full, 1'b0);
    @(negedge clk);
    chk("t1_start_once", core_start, 1'b0);
    tgt = n_results + 1;
    wait_results(tgt, 200);
    chk("t1_start_count", n_starts - s0, 1);

    // overflow: A runs, B pends, C and D are rejected
    load_job(8'hA0, 1'b0);
    lat_force = 120;
    commit();
    repeat (3) @(negedge clk);
    load_job(8'hB0, 1'b1);
    commit();
    chk("ovf_b_pending", pending_full, 1'b1);
    load_job(8'hC0, 1'b0);
    commit();
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_pending_kept", pending_full, 1'b1);
    job_commit = 1'b1; ovf_clr = 1'b1;
    @(negedge clk);
    job_commit = 1'b0; ovf_clr = 1'b0;
    chk("ovf_clr_vs_reject", overflow, 1'b1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    tgt = n_results + 2;
    wait_results(tgt, 400);

    // write and commit in the same cycle
    wr(5'd17, 32'h1111_1111);
    wr_en = 1'b1; wr_addr = 5'd17; wr_data = 32'hAAAA_AAAA; job_commit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; job_commit = 1'b0;
    tgt = n_results + 1;
    wait_results(tgt, 200);
    chk("wdc_launched_w17", last_w17, 32'h1111_1111);
    commit();
    tgt = n_results + 1;
    wait_results(tgt, 200);
    chk("wdc_shadow_w17", last_w17, 32'hAAAA_AAAA);

    // result backpressure with a job waiting in the pending slot
    load_job(8'hE0, 1'b0);
    lat_force = 40;
    commit();
    repeat (3) @(negedge clk);
    load_job(8'hF0, 1'b1);
    commit();
    chk("bp_pending", pending_full, 1'b1);
    hold_ready = 1;
    i = 0;
    while (!res_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk("bp_res_valid_seen", res_valid, 1'b1);
    s0 = n_starts;
    repeat (20) @(negedge clk);
    chk("bp_no_launch", n_starts, s0);
    chk("bp_pending_held", pending_full, 1'b1);
    chk("bp_valid_held", res_valid, 1'b1);
    hold_ready = 0;
    tgt = n_results + 2;
    wait_results(tgt, 300);
    chk("bp_launch_after_hs", n_starts, s0 + 1);

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) wr(5'($urandom_range(0, 31)), $urandom);
      if ($urandom_range(0, 3) != 0) begin
        job_commit = 1'b1;
        ovf_clr = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        job_commit = 1'b0; ovf_clr = 1'b0;
      end
      repeat ($urandom_range(0, 15)) @(negedge clk);
    end
    i = 0;
    while ((exp_jobs.size() != 0 || exp_res.size() != 0 || res_valid || busy) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("drain_busy", busy, 1'b0);
    chk("drain_exp_res", exp_res.size(), 0);

    // reset in the middle of a running job with another pending
    load_job(8'h77, 1'b1);
    lat_force = 60;
    commit();
    repeat (3) @(negedge clk);
    load_job(8'h78, 1'b0);
    commit();
    repeat (5) @(negedge clk);
    chk("rst_mid_busy", busy, 1'b1);
    #2 arst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    #2 arst_n = 1'b1;
    s0 = n_starts;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_rst_no_start", core_start, 1'b0);
    end
    chk("post_rst_start_count", n_starts, s0);
    chk("post_rst_no_result", res_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
